// File: rtl/wb_stage_mc.sv
// Multi-cycle writeback stage: selects IMM / PC+PC_INC / load data / ALU result, waits on a
// variable-latency memory response with timeout, and flags misaligned loads.
module wb_stage_mc #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned PC_INC  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu,
  input  logic [4:0]      rd,
  input  logic            reg_we,
  input  logic [1:0]      wb_sel,
  input  logic [2:0]      load_sel,
  input  logic [1:0]      dmem_sel,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] io_rdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [XLEN-1:0] bios_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  localparam int unsigned OffW = (XLEN == 64) ? 3 : 2;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [4:0]      rd_q;
  logic            reg_we_q;
  logic [2:0]      load_sel_q;
  logic [1:0]      dmem_sel_q;
  logic [OffW-1:0] off_q;

  logic            misaligned;
  logic [XLEN-1:0] direct_val;
  logic [XLEN-1:0] raw_rdata;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_val;

  assign in_ready = !rst && (state_q == StIdle);

  always_comb begin
    misaligned = 1'b0;
    case (load_sel)
      3'd1, 3'd5: misaligned = alu[0];
      3'd2, 3'd6: misaligned = |alu[1:0];
      3'd3:       misaligned = |alu[2:0];
      default:    misaligned = 1'b0;
    endcase

    direct_val = alu;
    case (wb_sel)
      2'd0:    direct_val = imm;
      2'd1:    direct_val = pc + XLEN'(PC_INC);
      default: direct_val = alu;
    endcase
  end

  // Load path works on captured controls; the rdata ports are only sampled on the response.
  always_comb begin
    raw_rdata = '0;
    case (dmem_sel_q)
      2'd0:    raw_rdata = io_rdata;
      2'd1:    raw_rdata = dmem_rdata;
      2'd2:    raw_rdata = bios_rdata;
      default: raw_rdata = '0;
    endcase

    shifted = raw_rdata >> {off_q, 3'b000};

    // On XLEN=32 the word and unsigned-word slices cover the whole datapath, so LW/LWU/LD
    // collapse to raw data without special-casing.
    load_val = shifted;
    case (load_sel_q)
      3'd0:    load_val = XLEN'(signed'(shifted[7:0]));
      3'd1:    load_val = XLEN'(signed'(shifted[15:0]));
      3'd2:    load_val = XLEN'(signed'(shifted[31:0]));
      3'd4:    load_val = XLEN'(shifted[7:0]);
      3'd5:    load_val = XLEN'(shifted[15:0]);
      3'd6:    load_val = XLEN'(shifted[31:0]);
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rd_q       <= '0;
      reg_we_q   <= 1'b0;
      load_sel_q <= '0;
      dmem_sel_q <= '0;
      off_q      <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_err     <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_err   <= 1'b0;
      if (state_q == StIdle) begin
        if (in_valid) begin
          rd_q       <= rd;
          reg_we_q   <= reg_we;
          load_sel_q <= load_sel;
          dmem_sel_q <= dmem_sel;
          off_q      <= alu[OffW-1:0];
          if (wb_sel != 2'd2) begin
            wb_valid <= 1'b1;
            wb_we    <= reg_we && (rd != 5'd0);
            wb_rd    <= rd;
            wb_data  <= direct_val;
          end else if (misaligned) begin
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            wb_rd    <= rd;
            wb_data  <= '0;
          end else begin
            state_q <= StWait;
            cnt_q   <= '0;
          end
        end
      end else begin
        cnt_q <= cnt_q + 8'd1;
        // A response in the final WAIT cycle takes priority over the timeout.
        if (mem_rsp_valid) begin
          wb_valid <= 1'b1;
          wb_we    <= reg_we_q && (rd_q != 5'd0);
          wb_rd    <= rd_q;
          wb_data  <= load_val;
          state_q  <= StIdle;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          wb_valid <= 1'b1;
          wb_err   <= 1'b1;
          wb_rd    <= rd_q;
          wb_data  <= '0;
          state_q  <= StIdle;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_mc.sv
// Scoreboard bench for wb_stage_mc: a 32-bit and a 64-bit instance share stimulus signals,
// each with its own expectation queue and monitor.
module tb_wb_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv32, iv64, mrv, reg_we;
  logic [63:0] pc, imm, alu, io_d, dm_d, bi_d;
  logic [4:0]  rd;
  logic [1:0]  wb_sel, dmem_sel;
  logic [2:0]  load_sel;

  logic        rdy32, v32, we32, err32;
  logic [4:0]  rd32;
  logic [31:0] d32;
  logic        rdy64, v64, we64, err64;
  logic [4:0]  rd64;
  logic [63:0] d64;

  int ntot = 0;
  int nbad = 0;

  typedef struct packed {
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  wb_stage_mc #(.XLEN(32), .TIMEOUT(16), .PC_INC(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32),
    .pc(pc[31:0]), .imm(imm[31:0]), .alu(alu[31:0]), .rd(rd), .reg_we(reg_we),
    .wb_sel(wb_sel), .load_sel(load_sel), .dmem_sel(dmem_sel), .mem_rsp_valid(mrv),
    .io_rdata(io_d[31:0]), .dmem_rdata(dm_d[31:0]), .bios_rdata(bi_d[31:0]),
    .wb_valid(v32), .wb_we(we32), .wb_rd(rd32), .wb_data(d32), .wb_err(err32)
  );

  wb_stage_mc #(.XLEN(64), .TIMEOUT(16), .PC_INC(4)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(rdy64),
    .pc(pc), .imm(imm), .alu(alu), .rd(rd), .reg_we(reg_we),
    .wb_sel(wb_sel), .load_sel(load_sel), .dmem_sel(dmem_sel), .mem_rsp_valid(mrv),
    .io_rdata(io_d), .dmem_rdata(dm_d), .bios_rdata(bi_d),
    .wb_valid(v64), .wb_we(we64), .wb_rd(rd64), .wb_data(d64), .wb_err(err64)
  );

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && v32) begin
      if (q32.size() == 0) begin
        cmp("wb32_unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        cmp("wb32_err", 64'(err32), 64'(e.err));
        cmp("wb32_we", 64'(we32), 64'(e.we));
        cmp("wb32_rd", 64'(rd32), 64'(e.rd));
        cmp("wb32_data", 64'(d32), 64'(e.data[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && v64) begin
      if (q64.size() == 0) begin
        cmp("wb64_unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q64.pop_front();
        cmp("wb64_err", 64'(err64), 64'(e.err));
        cmp("wb64_we", 64'(we64), 64'(e.we));
        cmp("wb64_rd", 64'(rd64), 64'(e.rd));
        cmp("wb64_data", d64, e.data);
      end
    end
  end

  task automatic expect_wb(input bit is64, input logic err, input logic we,
                           input logic [4:0] r, input logic [63:0] d);
    exp_t e;
    e = '{err: err, we: we, rd: r, data: d};
    if (is64) q64.push_back(e);
    else q32.push_back(e);
  endtask

  task automatic issue(input bit is64, input logic [1:0] ws, input logic [2:0] ls,
                       input logic [1:0] ds, input logic [63:0] a, input logic [4:0] r,
                       input logic we);
    @(negedge clk);
    wb_sel = ws; load_sel = ls; dmem_sel = ds; alu = a; rd = r; reg_we = we;
    if (is64) iv64 = 1'b1;
    else iv32 = 1'b1;
    cmp("accept_ready", 64'(is64 ? rdy64 : rdy32), 64'd1);
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    iv64 = 1'b0;
  endtask

  // Stall for n WAIT cycles, presenting the response in the n-th one.
  task automatic wait_rsp(input bit is64, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cmp("wait_stall", 64'(is64 ? rdy64 : rdy32), 64'd0);
      if (k == n) mrv = 1'b1;
    end
    @(posedge clk);
    #1;
    mrv = 1'b0;
    @(negedge clk);
    cmp("ready_after_rsp", 64'(is64 ? rdy64 : rdy32), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iv32 = 1'b0; iv64 = 1'b0; mrv = 1'b0; reg_we = 1'b0;
    pc = '0; imm = '0; alu = '0; io_d = '0; dm_d = '0; bi_d = '0;
    rd = '0; wb_sel = '0; dmem_sel = '0; load_sel = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp("reset_ready", 64'(rdy32), 64'd1);
    cmp("reset_valid", 64'(v32), 64'd0);
    cmp("reset_data", 64'(d32), 64'd0);
    cmp("reset_rd", 64'(rd32), 64'd0);
    cmp("reset_err_we", 64'({err32, we32}), 64'd0);

    // ALU result, then hold check
    expect_wb(0, 0, 1, 5'd5, 64'h1234);
    issue(0, 2'd3, 3'd0, 2'd1, 64'h1234, 5'd5, 1'b1);
    @(negedge clk);
    cmp("alu_ready_stays", 64'(rdy32), 64'd1);
    @(negedge clk);
    cmp("hold_valid_low", 64'(v32), 64'd0);
    cmp("hold_data", 64'(d32), 64'h1234);
    cmp("hold_rd", 64'(rd32), 64'd5);

    // Link wrap, rd=0 suppression, immediate: back-to-back
    pc = 64'hFFFF_FFFC;
    imm = 64'hDEAD_BEEF;
    expect_wb(0, 0, 1, 5'd6, 64'h0);
    issue(0, 2'd1, 3'd0, 2'd1, 64'h0, 5'd6, 1'b1);
    expect_wb(0, 0, 0, 5'd0, 64'h0);
    issue(0, 2'd1, 3'd0, 2'd1, 64'h0, 5'd0, 1'b1);
    expect_wb(0, 0, 1, 5'd31, 64'hDEAD_BEEF);
    issue(0, 2'd0, 3'd0, 2'd1, 64'h0, 5'd31, 1'b1);
    expect_wb(0, 0, 0, 5'd4, 64'h77);
    issue(0, 2'd3, 3'd0, 2'd1, 64'h77, 5'd4, 1'b0);

    // Loads with variable latency
    dm_d = 64'h80FF_0000;
    expect_wb(0, 0, 1, 5'd7, 64'hFFFF_FF80);
    issue(0, 2'd2, 3'd0, 2'd1, 64'h103, 5'd7, 1'b1);
    wait_rsp(0, 3);
    // LBU with a response pulse in the accept cycle, which must be ignored
    expect_wb(0, 0, 1, 5'd8, 64'h80);
    mrv = 1'b1;
    issue(0, 2'd2, 3'd4, 2'd1, 64'h103, 5'd8, 1'b1);
    mrv = 1'b0;
    wait_rsp(0, 3);
    io_d = 64'h8001_1234;
    expect_wb(0, 0, 1, 5'd13, 64'hFFFF_8001);
    issue(0, 2'd2, 3'd1, 2'd0, 64'h2, 5'd13, 1'b1);
    wait_rsp(0, 1);
    bi_d = 64'hFEDC_0000;
    expect_wb(0, 0, 1, 5'd14, 64'hFEDC);
    issue(0, 2'd2, 3'd5, 2'd2, 64'h2, 5'd14, 1'b1);
    wait_rsp(0, 2);
    expect_wb(0, 0, 1, 5'd15, 64'h0);
    issue(0, 2'd2, 3'd2, 2'd3, 64'h10, 5'd15, 1'b1);
    wait_rsp(0, 1);
    // Response in the same cycle the timeout would fire
    expect_wb(0, 0, 1, 5'd16, 64'h80FF_0000);
    issue(0, 2'd2, 3'd2, 2'd1, 64'h10, 5'd16, 1'b1);
    wait_rsp(0, 16);

    // Misaligned loads skip WAIT
    expect_wb(0, 1, 0, 5'd10, 64'h0);
    issue(0, 2'd2, 3'd1, 2'd1, 64'h1001, 5'd10, 1'b1);
    @(negedge clk);
    cmp("misaligned_lh_no_wait", 64'(rdy32), 64'd1);
    expect_wb(0, 1, 0, 5'd11, 64'h0);
    issue(0, 2'd2, 3'd2, 2'd1, 64'h1002, 5'd11, 1'b1);
    @(negedge clk);
    cmp("misaligned_lw_no_wait", 64'(rdy32), 64'd1);

    // Timeout after exactly 16 WAIT cycles, then immediate accept
    expect_wb(0, 1, 0, 5'd9, 64'h0);
    issue(0, 2'd2, 3'd2, 2'd1, 64'h100, 5'd9, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cmp("timeout_stall", 64'(rdy32), 64'd0);
    end
    expect_wb(0, 0, 1, 5'd12, 64'h55);
    issue(0, 2'd3, 3'd0, 2'd1, 64'h55, 5'd12, 1'b1);

    // Reset mid-WAIT, then a late response in IDLE
    issue(0, 2'd2, 3'd2, 2'd1, 64'h200, 5'd20, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_data", 64'(d32), 64'd0);
    cmp("abort_rd", 64'(rd32), 64'd0);
    mrv = 1'b1;
    @(negedge clk);
    mrv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("late_rsp_valid", 64'(v32), 64'd0);
      cmp("late_rsp_ready", 64'(rdy32), 64'd1);
      cmp("late_rsp_data", 64'(d32), 64'd0);
    end

    // XLEN=64 instance
    dm_d = 64'h8000_0000_0000_0001;
    expect_wb(1, 0, 1, 5'd3, 64'h8000_0000_0000_0001);
    issue(1, 2'd2, 3'd3, 2'd1, 64'h2000, 5'd3, 1'b1);
    wait_rsp(1, 2);
    dm_d = 64'h1234_5678_8000_0000;
    expect_wb(1, 0, 1, 5'd17, 64'hFFFF_FFFF_8000_0000);
    issue(1, 2'd2, 3'd2, 2'd1, 64'h2000, 5'd17, 1'b1);
    wait_rsp(1, 1);
    expect_wb(1, 0, 1, 5'd18, 64'h1234_5678);
    issue(1, 2'd2, 3'd6, 2'd1, 64'h2004, 5'd18, 1'b1);
    wait_rsp(1, 1);
    expect_wb(1, 1, 0, 5'd19, 64'h0);
    issue(1, 2'd2, 3'd3, 2'd1, 64'h2004, 5'd19, 1'b1);
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    expect_wb(1, 0, 1, 5'd21, 64'h0);
    issue(1, 2'd1, 3'd0, 2'd1, 64'h0, 5'd21, 1'b1);
    repeat (3) @(negedge clk);

    cmp("q32_drained", 64'(q32.size()), 64'd0);
    cmp("q64_drained", 64'(q64.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
